// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache, 4-word lines; hits complete in 0 cycles, misses
// hold Stall through evict/refill and honour mem_stall re-issue. `define DCACHE_STATS_EN adds hit/miss counters.
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int MEM_LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        mem_stall,
   input  logic [15:0] mem_rdata,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);
   localparam int IDX  = $clog2(NUM_LINES);
   localparam int TAGW = 13 - IDX;

   typedef enum logic [2:0] {S_IDLE, S_EVICT, S_FILL, S_WAITF, S_DONE} state_t;

   state_t              state_q;
   logic [15:0]         addr_q, din_q;
   logic                wr_q;
   logic [1:0]          cnt_q;
   logic [2:0]          ret_cnt_q;
   logic [MEM_LAT-1:0]  pipe_vld_q;
   logic [1:0]          pipe_off_q [MEM_LAT];
   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TAGW-1:0]     tag_q  [NUM_LINES];
   logic [15:0]         data_q [NUM_LINES][4];
   logic [15:0]         lbuf_q [4];

   logic [IDX-1:0]  req_idx, l_idx;
   logic [TAGW-1:0] req_tag, l_tag;
   logic [1:0]      req_off, l_off, ret_off;
   logic            illegal, legal, idle, hit, hit_go, miss_go, ret_vld, push, install;

   assign req_idx = Addr[3+IDX-1:3];
   assign req_tag = Addr[15:3+IDX];
   assign req_off = Addr[2:1];
   assign l_idx   = addr_q[3+IDX-1:3];
   assign l_tag   = addr_q[15:3+IDX];
   assign l_off   = addr_q[2:1];
   assign illegal = (Rd & Wr) | (Addr[0] & (Rd | Wr));
   assign legal   = (Rd | Wr) & ~illegal;
   // Reset gates the combinational IDLE responses so nothing glitches while rst is high.
   assign idle    = (state_q == S_IDLE) && !rst;
   assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit_go  = idle & legal & hit;
   assign miss_go = idle & legal & ~hit;
   assign ret_vld = pipe_vld_q[MEM_LAT-1];
   assign ret_off = pipe_off_q[MEM_LAT-1];
   assign push    = (state_q == S_FILL) && !mem_stall;
   assign install = (state_q == S_WAITF) && (ret_cnt_q == 3'd4);

   always_comb begin
      DataOut   = 16'h0000;
      Done      = 1'b0;
      Stall     = 1'b0;
      CacheHit  = 1'b0;
      err       = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            err      = idle & illegal;
            Done     = hit_go;
            CacheHit = hit_go;
            Stall    = miss_go;
            if (hit_go && Rd) DataOut = data_q[req_idx][req_off];
         end
         S_EVICT: begin
            Stall     = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {tag_q[l_idx], l_idx, cnt_q, 1'b0};
            mem_wdata = data_q[l_idx][cnt_q];
         end
         S_FILL: begin
            Stall    = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {l_tag, l_idx, cnt_q, 1'b0};
         end
         S_WAITF: Stall = 1'b1;
         S_DONE: begin
            Done    = 1'b1;
            DataOut = data_q[l_idx][l_off];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 16'h0000;
         din_q      <= 16'h0000;
         wr_q       <= 1'b0;
         cnt_q      <= 2'd0;
         ret_cnt_q  <= 3'd0;
         pipe_vld_q <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         for (int i = 0; i < MEM_LAT; i++) pipe_off_q[i] <= 2'd0;
      end else begin
         // Word offsets ride a MEM_LAT-deep pipe so each return lands in the right buffer slot.
         pipe_vld_q[0] <= push;
         pipe_off_q[0] <= cnt_q;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_off_q[i] <= pipe_off_q[i-1];
         end
         if (ret_vld) ret_cnt_q <= ret_cnt_q + 3'd1;
         case (state_q)
            S_IDLE: begin
               cnt_q     <= 2'd0;
               ret_cnt_q <= 3'd0;
               if (hit_go && Wr) dirty_q[req_idx] <= 1'b1;
               if (miss_go) begin
                  addr_q  <= Addr;
                  din_q   <= DataIn;
                  wr_q    <= Wr;
                  state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? S_EVICT : S_FILL;
               end
            end
            S_EVICT: if (!mem_stall) begin
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_q <= S_FILL;
            end
            S_FILL: if (!mem_stall) begin
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_q <= S_WAITF;
            end
            S_WAITF: if (install) begin
               valid_q[l_idx] <= 1'b1;
               dirty_q[l_idx] <= wr_q;
               state_q        <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ret_vld) lbuf_q[ret_off] <= mem_rdata;
      if (hit_go && Wr) data_q[req_idx][req_off] <= DataIn;
      if (install) begin
         tag_q[l_idx] <= l_tag;
         for (int w = 0; w < 4; w++)
            data_q[l_idx][w] <= (wr_q && (l_off == 2'(w))) ? din_q : lbuf_q[w];
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= 16'h0000;
         miss_cnt_q <= 16'h0000;
      end else if (Done) begin
         if (CacheHit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
         if (!CacheHit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'h0000;
   assign miss_cnt = 16'h0000;
`endif
endmodule
